// File: rtl/clk_meas_pkg.sv
// Shared definitions for the signal frequency/duty measurement blocks.
package clk_meas_pkg;

   // Measurement controller state encoding.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   // Default width of the period / high-time counters.
   localparam int DEFAULT_WIDTH = 32;

   // Fewest synchronizer flops that still give metastability protection.
   localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous input into the clock_in domain and flags
// its rising edges. sig_s is the synchronized level; rise is high for the
// single cycle in which sig_s is 1 after having been 0 the cycle before.
module edge_sync
   import clk_meas_pkg::*;
#(
   parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
   input  logic clock_in,
   input  logic reset,
   input  logic sig_async,
   output logic sig_s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the raw input through the synchronizer chain and keep one cycle
   // of edge history; both run in every controller state.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_async};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sig_s = sync_q[SYNC_STAGES-1];
   assign rise  = sig_s & ~prev_q;

endmodule

// File: rtl/clk_freqmeter.sv
// Measures period (rise to rise) and high time of an asynchronous periodic
// signal in clock_in cycles. A one-cycle meas_valid accompanies each new
// result; a sticky timeout reports an input with no rising edge for
// TIMEOUT cycles. state_dbg exposes the controller state for observation.
module clk_freqmeter
   import clk_meas_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int SYNC_STAGES = MIN_SYNC_STAGES,
   parameter int TIMEOUT     = 1000000
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period_clks,
   output logic [WIDTH-1:0] high_clks,
   output logic             meas_valid,
   output logic             timeout,
   output logic             busy,
   output state_t           state_dbg
);

   // Timer value at which the input is declared stalled.
   localparam logic [WIDTH-1:0] TIMER_LAST = WIDTH'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] period_cnt;
   logic [WIDTH-1:0] high_cnt;
   logic [WIDTH-1:0] timer;
   logic             sig_s;
   logic             rise;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clock_in  (clock_in),
      .reset     (reset),
      .sig_async (sig_in),
      .sig_s     (sig_s),
      .rise      (rise)
   );

   // Controller: arm on a genuine 0->1 edge, count each period, publish on
   // the closing edge. Priority inside ARM/MEASURE: enable drop, then a
   // rise, then the timeout, then ordinary counting.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         period_cnt  <= '0;
         high_cnt    <= '0;
         timer       <= '0;
         period_clks <= '0;
         high_clks   <= '0;
         meas_valid  <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state)
            IDLE: begin
               period_cnt <= '0;
               high_cnt   <= '0;
               timer      <= '0;
               if (enable) state <= ARM;
            end
            ARM, MEASURE: begin
               if (!enable) begin
                  state      <= IDLE;
                  period_cnt <= '0;
                  high_cnt   <= '0;
                  timer      <= '0;
                  timeout    <= 1'b0;
               end else if (rise) begin
                  // In ARM this edge only opens the first period.
                  if (state == MEASURE) begin
                     period_clks <= period_cnt;
                     high_clks   <= high_cnt;
                     meas_valid  <= 1'b1;
                     timeout     <= 1'b0;
                  end
                  period_cnt <= CNT_ONE;
                  high_cnt   <= CNT_ONE;
                  timer      <= '0;
                  state      <= MEASURE;
               end else if (timer == TIMER_LAST) begin
                  timeout     <= 1'b1;
                  period_clks <= '0;
                  high_clks   <= '0;
                  period_cnt  <= '0;
                  high_cnt    <= '0;
                  timer       <= '0;
                  state       <= ARM;
               end else begin
                  timer <= sat_inc(timer);
                  if (state == MEASURE) begin
                     period_cnt <= sat_inc(period_cnt);
                     if (sig_s) high_cnt <= sat_inc(high_cnt);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_clk_freqmeter.sv
// Directed bench for clk_freqmeter: table of square waves with hand-computed
// period/high results, plus sequences for reset, timeout, enable drop and
// asynchronous reset in mid-measurement.
module tb_clk_freqmeter;
   import clk_meas_pkg::*;

   localparam int W  = 32;
   localparam int TO = 100;

   logic         clock_in = 1'b0;
   logic         reset;
   logic         enable;
   logic         sig_in;
   logic [W-1:0] period_clks;
   logic [W-1:0] high_clks;
   logic         meas_valid;
   logic         timeout;
   logic         busy;
   state_t       state_dbg;

   // ---------------- clock / reset ----------------
   always #5 clock_in = ~clock_in;

   clk_freqmeter #(
      .WIDTH       (W),
      .SYNC_STAGES (2),
      .TIMEOUT     (TO)
   ) dut (
      .clock_in    (clock_in),
      .reset       (reset),
      .enable      (enable),
      .sig_in      (sig_in),
      .period_clks (period_clks),
      .high_clks   (high_clks),
      .meas_valid  (meas_valid),
      .timeout     (timeout),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: log every meas_valid with its values, cycle and timeout context.
   int           cyc = 0;
   logic [W-1:0] vq[$];
   logic [W-1:0] hq[$];
   int           cq[$];
   logic         to_before_q[$];
   logic         to_at_q[$];
   logic         to_prev = 1'b0;

   always @(posedge clock_in) cyc++;

   always @(negedge clock_in) begin
      if (meas_valid === 1'b1) begin
         vq.push_back(period_clks);
         hq.push_back(high_clks);
         cq.push_back(cyc);
         to_before_q.push_back(to_prev);
         to_at_q.push_back(timeout);
      end
      to_prev = timeout;
   end

   task automatic clear_log();
      vq.delete(); hq.delete(); cq.delete();
      to_before_q.delete(); to_at_q.delete();
   endtask

   // ---------------- drivers (called at posedge+1) ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock_in);
         #1;
      end
   endtask

   task automatic drive_wave(input int hi, input int lo, input int n);
      for (int p = 0; p < n; p++) begin
         sig_in = 1'b1;
         tick(hi);
         sig_in = 1'b0;
         tick(lo);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int           hi;
      int           lo;
      logic [W-1:0] exp_p;
      logic [W-1:0] exp_h;
   } vec_t;

   vec_t vecs[6];

   // Watchdog so a stuck run still ends with a report.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int k;
      int v0;

      vecs[0] = '{hi: 2, lo: 2, exp_p: 4,  exp_h: 2};
      vecs[1] = '{hi: 3, lo: 7, exp_p: 10, exp_h: 3};
      vecs[2] = '{hi: 5, lo: 5, exp_p: 10, exp_h: 5};
      vecs[3] = '{hi: 1, lo: 1, exp_p: 2,  exp_h: 1};
      vecs[4] = '{hi: 1, lo: 3, exp_p: 4,  exp_h: 1};
      vecs[5] = '{hi: 4, lo: 1, exp_p: 5,  exp_h: 4};

      // ---- reset held: outputs stay 0 while input toggles ----
      reset  = 1'b0;
      enable = 1'b1;
      sig_in = 1'b0;
      @(posedge clock_in); #1;
      for (int i = 0; i < 8; i++) begin
         sig_in = ~sig_in;
         tick(1);
         check("rst_period", period_clks, 0);
         check("rst_high", high_clks, 0);
         check("rst_valid", W'(meas_valid), 0);
         check("rst_timeout", W'(timeout), 0);
         check("rst_busy", W'(busy), 0);
      end
      sig_in = 1'b0;
      reset  = 1'b1;
      #1;
      check("release_busy_before_edge", W'(busy), 0);
      tick(1);
      check("release_busy_after_edge", W'(busy), 1);
      check("release_state_arm", W'(state_dbg), W'(ARM));

      // ---- table: last three results of each wave must match ----
      for (int v = 0; v < 6; v++) begin
         clear_log();
         drive_wave(vecs[v].hi, vecs[v].lo, 4);
         sig_in = 1'b0;
         tick(6);
         n = vq.size();
         check($sformatf("v%0d_valid_count_ge3", v), W'(n >= 3), 1);
         if (n >= 3) begin
            for (int j = 0; j < 3; j++) exp_q.push_back(vecs[v].exp_p);
            for (int i = n - 3; i < n; i++) begin
               check($sformatf("v%0d_period[%0d]", v, i), vq[i], exp_q.pop_front());
               check($sformatf("v%0d_high[%0d]", v, i), hq[i], vecs[v].exp_h);
               if (i > n - 3)
                  check($sformatf("v%0d_spacing[%0d]", v, i), W'(cq[i] - cq[i-1]),
                        W'(vecs[v].hi + vecs[v].lo));
            end
         end
      end

      // ---- enable drop mid-period, outputs hold ----
      drive_wave(2, 2, 3);
      sig_in = 1'b1;
      tick(5);                      // closing rise of a 2/2 period lands here
      check("pre_drop_period", period_clks, 4);
      check("pre_drop_high", high_clks, 2);
      v0 = vq.size();
      enable = 1'b0;
      tick(1);
      check("drop_busy", W'(busy), 0);
      tick(10);
      check("drop_no_valid", W'(vq.size()), W'(v0));
      check("drop_hold_period", period_clks, 4);
      check("drop_hold_high", high_clks, 2);
      check("drop_timeout_clear", W'(timeout), 0);

      // ---- re-enable with input already high: needs a fresh 0->1 ----
      enable = 1'b1;
      tick(1);
      check("reen_busy", W'(busy), 1);
      tick(20);
      check("reen_high_level_no_valid", W'(vq.size()), W'(v0));
      sig_in = 1'b0;
      tick(2);
      drive_wave(2, 2, 2);
      sig_in = 1'b0;
      tick(6);
      check("reen_one_valid", W'(vq.size()), W'(v0 + 1));
      if (vq.size() > v0) begin
         check("reen_first_period", vq[v0], 4);
         check("reen_first_high", hq[v0], 2);
      end

      // ---- timeout after TO cycles in ARM with a static-low input ----
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      tick(1);                      // ARM entered on this edge
      check("to_arm_entered", W'(state_dbg), W'(ARM));
      k = 0;
      while (k < 300) begin
         tick(1);
         k++;
         if (timeout === 1'b1) break;
      end
      check("to_cycles_after_arm", W'(k), W'(TO));
      check("to_period_zero", period_clks, 0);
      check("to_high_zero", high_clks, 0);
      check("to_state_arm", W'(state_dbg), W'(ARM));

      // ---- timeout drops together with the first meas_valid ----
      clear_log();
      drive_wave(2, 2, 3);
      sig_in = 1'b0;
      tick(6);
      check("to_recover_count", W'(vq.size()), 2);
      if (vq.size() > 0) begin
         check("to_recover_period", vq[0], 4);
         check("to_recover_high", hq[0], 2);
         check("to_high_before_valid", W'(to_before_q[0]), 1);
         check("to_low_at_valid", W'(to_at_q[0]), 0);
      end

      // ---- asynchronous reset between clock edges mid-MEASURE ----
      drive_wave(2, 2, 2);
      check("async_pre_state", W'(state_dbg), W'(MEASURE));
      #3;
      reset = 1'b0;
      #1;
      check("async_period", period_clks, 0);
      check("async_high", high_clks, 0);
      check("async_busy", W'(busy), 0);
      check("async_state_idle", W'(state_dbg), W'(IDLE));
      tick(1);
      check("async_held_idle", W'(state_dbg), W'(IDLE));
      reset = 1'b1;
      tick(1);
      check("async_release_busy", W'(busy), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_freqmeter.md
Name: clk_freqmeter

Overview:
Measures an incoming periodic digital signal, such as the divided clock produced by our frequency divider, in units of the system clock. It reports period length and high time in clock cycles, with a one-cycle valid strobe per completed period. A sticky timeout flags a stalled or absent input. It is the receiving end of the divider: the divider generates a frequency, and this block recovers it.

Parameters:
WIDTH, 32, width of the period and high-time counters and outputs
SYNC_STAGES, 2, number of synchronizer flops on sig_in (minimum 2)
TIMEOUT, 1000000, cycles without a rising edge before timeout is raised; must be less than 2^WIDTH-1

Ports:
clock_in  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  1 = measure; 0 = return to idle
sig_in  input  1  asynchronous signal under measurement
period_clks  output  WIDTH  last measured period, rise to rise, in clock_in cycles
high_clks  output  WIDTH  last measured high time in clock_in cycles
meas_valid  output  1  one-cycle pulse when period_clks and high_clks update
timeout  output  1  sticky flag: no rising edge within TIMEOUT cycles
busy  output  1  1 when state is not IDLE

Behaviour:
- Reset asserted: all outputs 0, synchronizer flops 0, edge-history flop 0, counters 0, state IDLE. Takes effect immediately and mid-operation.
- Synchronizer: sig_in passes through SYNC_STAGES flops to give sig_s.
  - prev captures sig_s every cycle, in all states.
  - rise = sig_s & ~prev.
  - The first cycle with rise is SYNC_STAGES+1 clocks after sig_in goes high.
- State IDLE: period_cnt, high_cnt and timer held at 0. If enable=1, go to ARM next cycle.
- State ARM:
  - Waits for rise. If sig_s is already high on entry, that level is not counted; a genuine 0->1 transition is required.
  - On rise: period_cnt<=1, high_cnt<=1, timer<=0, go to MEASURE.
- State MEASURE:
  - period_cnt increments every cycle.
  - high_cnt increments each cycle sig_s=1.
  - On rise: period_clks<=period_cnt, high_clks<=high_cnt, meas_valid<=1 for that one cycle, timeout<=0. Counters restart at 1, timer<=0.
- Timer:
  - Increments every cycle in ARM and MEASURE.
  - If timer reaches TIMEOUT-1 with no rise that cycle: timeout<=1, period_clks<=0, high_clks<=0, counters and timer cleared, go to ARM.
  - A rise in the same cycle takes priority over the timeout.
- timeout clears only on the next meas_valid or when enable=0.
- enable=0 in ARM or MEASURE:
  - Next cycle: state IDLE, counters cleared, timeout<=0, no meas_valid.
  - period_clks and high_clks hold their last values.
- Counters saturate at all-ones and never wrap. The TIMEOUT bound guarantees saturation is unreachable in normal use.
- Static input (constant 0 or 1) never produces meas_valid, only a timeout.
- Latency: outputs update in the cycle after the detected rise that closes a period.

Decomposition:
- Shared package clk_meas_pkg holds:
  - the state enum (IDLE, ARM, MEASURE);
  - the default WIDTH of 32;
  - the minimum SYNC_STAGES of 2.
- One sub-module, edge_sync: the SYNC_STAGES synchronizer plus the prev flop, with outputs sig_s and rise. It is reused by other asynchronous-input blocks.
- The FSM, counters and timer live in clk_freqmeter.

Test Plan:
1. Reset check: hold reset=0, toggle sig_in, enable=1 -> all outputs 0 and busy=0 throughout. Release reset -> busy=1 one cycle after release.
2. Square wave, 2 high / 2 low: enable=1 -> the first meas_valid comes on the second detected rise, with period_clks=4 and high_clks=2. meas_valid then repeats every 4 cycles, one cycle wide.
3. Asymmetric duty, 3 high / 7 low -> period_clks=10, high_clks=3. Switch to 5 high / 5 low -> the next valid gives 10 and 5.
4. Timeout with TIMEOUT=100: sig_in held 0 after enable -> timeout=1 exactly 100 cycles after entering ARM, and outputs read 0. Then apply the 2/2 wave -> timeout drops together with the first meas_valid.
5. Enable drop: deassert enable mid-period -> busy=0 next cycle, no meas_valid, and period_clks/high_clks keep their prior values. With sig_in held high, re-enable -> no measurement until a fresh 0->1 transition.
6. Asynchronous reset mid-MEASURE, applied between clock edges -> outputs go to 0 before the next clock_in edge, and state returns to IDLE.
